mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single off-chip memory port between several requesters, for example the K/V/Q load engine and the O drain engine, so that loads and stores can overlap. Each cycle it round-robin grants one requester's command to memory. It records the owner of every accepted load tag and routes returned load data back to that owner. It sits between the requester engines and the `proc2mem_*` / `mem2proc_*` memory interface.

## Interface
- `NUM_REQ`, 2, number of requesters (2..4); `REQ_ID_W = $clog2(NUM_REQ)`, minimum 1
- `TAG_W`, `$bits(MEM_TAG)`, tag width; the owner table has `2**TAG_W` entries, and tag 0 means "no tag"
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req_vld[NUM_REQ]`  in  1  requester i presents a command
- `req_cmd[NUM_REQ]`  in  MEM_COMMAND  MEM_LOAD or MEM_STORE; MEM_NONE is treated as not valid
- `req_addr[NUM_REQ]`  in  ADDR  block-aligned address
- `req_data[NUM_REQ]`  in  MEM_BLOCK  store data
- `req_rdy[NUM_REQ]`  out  1  command accepted by memory this cycle
- `rsp_vld[NUM_REQ]`  out  1  load data for requester i this cycle
- `rsp_data`  out  MEM_BLOCK  returned block, shared by all requesters
- `proc2mem_command`, `proc2mem_addr`, `proc2mem_data`  out  memory command, address and data
- `mem2proc_transaction_tag`  in  MEM_TAG  nonzero means the command was accepted
- `mem2proc_data`, `mem2proc_data_tag`  in  returned block and its tag (0 means nothing returned)
- `loads_outstanding`  out  `$clog2(2**TAG_W+1)`  count of loads issued but not yet returned
- `idle`  out  1  `loads_outstanding == 0`
- `stray_rsp`  out  1  sticky flag: data returned on a tag that is not in the owner table

## Operation
- **Arbitration (combinational):**
  - Round-robin pointer `rr_ptr` (REQ_ID_W bits). The winner is the first `i` with `req_vld[i]`, scanning upward from `rr_ptr` and wrapping.
  - Winner's cmd/addr/data drive `proc2mem_*`. Store data drives `proc2mem_data` only for MEM_STORE; otherwise `proc2mem_data = 0`.
  - If there is no winner, `proc2mem_command = MEM_NONE`, `proc2mem_addr = 0` and `proc2mem_data = 0`.
- **Acceptance:**
  - `req_rdy[winner] = (mem2proc_transaction_tag != 0)`. All other `req_rdy` are 0.
  - A requester holds cmd/addr/data stable until `req_rdy` is seen.
  - On acceptance, `rr_ptr <= winner + 1`, wrapping modulo NUM_REQ.
  - On rejection (tag 0), `rr_ptr` is unchanged, so the same requester retries.
- **Owner table** (`valid[tag]`, `owner[tag]`):
  - An accepted MEM_LOAD sets `valid[tag] = 1` and `owner[tag] = winner`, and increments `loads_outstanding`.
  - An accepted MEM_STORE writes no table entry.
- **Return:**
  - If `mem2proc_data_tag != 0` and `valid[data_tag]`: `rsp_vld[owner[data_tag]] = 1` and `rsp_data = mem2proc_data`, combinationally in the same cycle. The entry is cleared and `loads_outstanding` decrements.
  - If `data_tag != 0` and the entry is not valid: no `rsp_vld`, and `stray_rsp` is set, staying 1 until reset.
- **Simultaneous issue and return in one cycle:**
  - Return processing reads the table as registered at the start of the cycle.
  - The new load's write is applied after the clear, so an identical tag ends valid with the new owner.
  - If both happen, the counter is net unchanged.
- Requesters must consume `rsp_vld` immediately; there is no back-pressure on responses.
- **Invariant (assertion):** `loads_outstanding` never exceeds `2**TAG_W - 1`.

## Timing
- Request to `req_rdy`: 0 cycles (same cycle). Data return to `rsp_vld`: 0 cycles.
- Table, counter, `rr_ptr` and `stray_rsp` update on the rising edge after the event.
- **Reset (async, `rst = 0`):**
  - `rr_ptr = 0`, all `valid = 0`, `loads_outstanding = 0`, `stray_rsp = 0`.
  - Outputs during reset: `proc2mem_command = MEM_NONE` (arbitration forced off), `req_rdy = 0`, `rsp_vld = 0`, `idle = 1`.
- Reset mid-operation: in-flight loads are forgotten. Later returns on their tags raise `stray_rsp` and are dropped.

## Configuration
- `MEM_ARB_STATS_EN` defined:
  - Adds outputs `stat_loads`, `stat_stores` and `stat_rejects` (32 bits each, saturating).
  - They count accepted loads, accepted stores, and cycles with a winner but transaction tag 0.
  - All three reset to 0.
- Not defined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `sys_defs.svh`:
  - Already holds MEM_COMMAND, MEM_TAG, MEM_BLOCK and ADDR.
  - Add `MEM_REQ_T` (cmd, addr, data) and `NUM_MEM_REQUESTERS`.
- Sub-module `rr_arbiter #(N)`:
  - Inputs: `req[N]` and `ptr`.
  - Outputs: one-hot `gnt`, `gnt_id` and `any`.
  - Purely combinational; `rr_ptr` stays in the parent.

## Test plan
- Single load: req0 LOAD to 0x100, memory tag 3, data tag 3 with 0xDEAD_BEEF two cycles later -> `req_rdy[0]=1` in the issue cycle; `rsp_vld[0]=1` with `rsp_data=0xDEAD_BEEF`; `idle` back to 1.
- Contention: req0 and req1 both valid every cycle, all accepted -> grants alternate 0,1,0,1; `rr_ptr` wraps.
- Rejection: memory returns tag 0 for 3 cycles -> `req_rdy` stays 0 and the same requester remains winner; with stats enabled, `stat_rejects=3`.
- Interleaved returns: req0 load tag 5, req1 load tag 6, data returns tag 6 then tag 5 -> `rsp_vld[1]` then `rsp_vld[0]`; `loads_outstanding` goes 2,1,0.
- Same-cycle reuse: return on tag 4 (owner 0) while req1's load is accepted with tag 4 -> `rsp_vld[0]=1`; the entry then holds owner 1; the count is unchanged.
- Reset mid-flight: load tag 2 outstanding, pulse `rst` low, then data tag 2 returns -> no `rsp_vld`; `stray_rsp=1`; `loads_outstanding=0`.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: memory-interface types shared by the arbiter and its requesters.
//   MEM_COMMAND / MEM_TAG / MEM_BLOCK / ADDR : off-chip memory port types
//   MEM_REQ_T                                : one requester command (cmd, addr, data)
//   NUM_MEM_REQUESTERS                       : default requester count
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } MEM_COMMAND;

    typedef logic [3:0]  MEM_TAG;
    typedef logic [63:0] MEM_BLOCK;
    typedef logic [31:0] ADDR;

    typedef struct packed {
        MEM_COMMAND cmd;
        ADDR        addr;
        MEM_BLOCK   data;
    } MEM_REQ_T;

    localparam int NUM_MEM_REQUESTERS = 2;

    function automatic logic is_mem_op(input MEM_COMMAND c);
        return (c == MEM_LOAD) || (c == MEM_STORE);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
//   req    : request vector
//   ptr    : scan start position (kept by the parent)
//   gnt    : one-hot grant
//   gnt_id : index of the granted request
//   any    : at least one request present
module rr_arbiter #(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_id,
    output logic         any
);

    logic [W-1:0] w_idx;

    // Scan from the farthest offset down so the nearest request to ptr is written last and wins.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        w_idx  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = W'((int'(ptr) + k) % N);
            if (req[w_idx]) begin
                gnt        = '0;
                gnt[w_idx] = 1'b1;
                gnt_id     = w_idx;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port with load-tag ownership tracking.
//   clk, rst (async, active low)
//   req_vld/req_cmd/req_addr/req_data -> req_rdy : requester commands, same-cycle acceptance
//   rsp_vld/rsp_data                             : returned load data routed to its owner
//   proc2mem_* / mem2proc_*                      : memory interface
//   loads_outstanding, idle, stray_rsp           : status
//   stat_loads/stat_stores/stat_rejects          : only when MEM_ARB_STATS_EN is defined
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_MEM_REQUESTERS,
    parameter int TAG_W   = $bits(MEM_TAG),
    localparam int REQ_ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W    = $clog2(2**TAG_W + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_vld,
    input  MEM_COMMAND         req_cmd  [NUM_REQ],
    input  ADDR                req_addr [NUM_REQ],
    input  MEM_BLOCK           req_data [NUM_REQ],
    output logic [NUM_REQ-1:0] req_rdy,
    output logic [NUM_REQ-1:0] rsp_vld,
    output MEM_BLOCK           rsp_data,
    output MEM_COMMAND         proc2mem_command,
    output ADDR                proc2mem_addr,
    output MEM_BLOCK           proc2mem_data,
    input  logic [TAG_W-1:0]   mem2proc_transaction_tag,
    input  MEM_BLOCK           mem2proc_data,
    input  logic [TAG_W-1:0]   mem2proc_data_tag,
    output logic [CNT_W-1:0]   loads_outstanding,
    output logic               idle,
    output logic               stray_rsp
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]        stat_loads,
    output logic [31:0]        stat_stores,
    output logic [31:0]        stat_rejects
`endif
);

    localparam int DEPTH = 2**TAG_W;

    MEM_REQ_T            w_req [NUM_REQ];
    MEM_REQ_T            w_win;
    logic [NUM_REQ-1:0]  w_req_vld;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [REQ_ID_W-1:0] w_gnt_id;
    logic                w_any;
    logic                w_accept;
    logic                w_ld_issue;
    logic                w_ret_hit;
    logic                w_stray;

    logic [REQ_ID_W-1:0] r_rr_ptr;
    logic [DEPTH-1:0]    r_valid;
    logic [REQ_ID_W-1:0] r_owner [DEPTH];
    logic [CNT_W-1:0]    r_cnt;
    logic                r_stray;

    // Gating with rst keeps the port silent while reset is asserted.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_req[i].cmd  = req_cmd[i];
            w_req[i].addr = req_addr[i];
            w_req[i].data = req_data[i];
            w_req_vld[i]  = rst && req_vld[i] && is_mem_op(req_cmd[i]);
        end
    end

    rr_arbiter #(.N(NUM_REQ), .W(REQ_ID_W)) u_rr_arbiter (
        .req    (w_req_vld),
        .ptr    (r_rr_ptr),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id),
        .any    (w_any)
    );

    assign w_win            = w_req[w_gnt_id];
    assign w_accept         = w_any && (mem2proc_transaction_tag != '0);
    assign w_ld_issue       = w_accept && (w_win.cmd == MEM_LOAD);
    assign proc2mem_command = w_any ? w_win.cmd : MEM_NONE;
    assign proc2mem_addr    = w_any ? w_win.addr : '0;
    assign proc2mem_data    = (w_any && (w_win.cmd == MEM_STORE)) ? w_win.data : '0;
    assign req_rdy          = w_accept ? w_gnt : '0;

    // Returns look at the table as registered at the start of the cycle.
    assign w_ret_hit = rst && (mem2proc_data_tag != '0) && r_valid[mem2proc_data_tag];
    assign w_stray   = rst && (mem2proc_data_tag != '0) && !r_valid[mem2proc_data_tag];
    assign rsp_vld   = w_ret_hit ? (NUM_REQ'(1) << r_owner[mem2proc_data_tag]) : '0;
    assign rsp_data  = mem2proc_data;

    assign loads_outstanding = r_cnt;
    assign idle              = (r_cnt == '0);
    assign stray_rsp         = r_stray;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr <= '0;
            r_valid  <= '0;
            r_cnt    <= '0;
            r_stray  <= 1'b0;
        end else begin
            if (w_accept)
                r_rr_ptr <= (w_gnt_id == REQ_ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + REQ_ID_W'(1);
            // Set after clear: a tag reused in the cycle it returns stays valid for the new load.
            if (w_ret_hit)
                r_valid[mem2proc_data_tag] <= 1'b0;
            if (w_ld_issue)
                r_valid[mem2proc_transaction_tag] <= 1'b1;
            if (w_ld_issue != w_ret_hit)
                r_cnt <= w_ld_issue ? r_cnt + CNT_W'(1) : r_cnt - CNT_W'(1);
            if (w_stray)
                r_stray <= 1'b1;
        end
    end

    // Owner is only meaningful while its valid bit is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_ld_issue)
            r_owner[mem2proc_transaction_tag] <= w_gnt_id;
    end

    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst) r_cnt <= CNT_W'(DEPTH - 1));

`ifdef MEM_ARB_STATS_EN
    logic        w_st_issue;
    logic        w_reject;
    logic [31:0] r_stat_loads;
    logic [31:0] r_stat_stores;
    logic [31:0] r_stat_rejects;

    assign w_st_issue   = w_accept && (w_win.cmd == MEM_STORE);
    assign w_reject     = w_any && (mem2proc_transaction_tag == '0);
    assign stat_loads   = r_stat_loads;
    assign stat_stores  = r_stat_stores;
    assign stat_rejects = r_stat_rejects;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_loads   <= '0;
            r_stat_stores  <= '0;
            r_stat_rejects <= '0;
        end else begin
            if (w_ld_issue && (r_stat_loads != '1))
                r_stat_loads <= r_stat_loads + 32'd1;
            if (w_st_issue && (r_stat_stores != '1))
                r_stat_stores <= r_stat_stores + 32'd1;
            if (w_reject && (r_stat_rejects != '1))
                r_stat_rejects <= r_stat_rejects + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a tag-table reference model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_vld;
    MEM_COMMAND req_cmd  [2];
    ADDR        req_addr [2];
    MEM_BLOCK   req_data [2];
    logic [1:0] req_rdy;
    logic [1:0] rsp_vld;
    MEM_BLOCK   rsp_data;
    MEM_COMMAND p_cmd;
    ADDR        p_addr;
    MEM_BLOCK   p_data;
    MEM_TAG     t_tag;
    MEM_BLOCK   m_data;
    MEM_TAG     d_tag;
    logic [4:0] lo;
    logic       idle;
    logic       stray;

    int errors = 0;
    int checks = 0;

    bit m_valid [16];
    int m_owner [16];
    int m_cnt;
    int m_rr;
    bit m_stray;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk                      (clk),
        .rst                      (rst),
        .req_vld                  (req_vld),
        .req_cmd                  (req_cmd),
        .req_addr                 (req_addr),
        .req_data                 (req_data),
        .req_rdy                  (req_rdy),
        .rsp_vld                  (rsp_vld),
        .rsp_data                 (rsp_data),
        .proc2mem_command         (p_cmd),
        .proc2mem_addr            (p_addr),
        .proc2mem_data            (p_data),
        .mem2proc_transaction_tag (t_tag),
        .mem2proc_data            (m_data),
        .mem2proc_data_tag        (d_tag),
        .loads_outstanding        (lo),
        .idle                     (idle),
        .stray_rsp                (stray)
    );

    task automatic m_reset();
        for (int t = 0; t < 16; t++) m_valid[t] = 0;
        m_cnt = 0; m_rr = 0; m_stray = 0;
    endtask

    function automatic int m_winner();
        for (int k = 0; k < 2; k++) begin
            if (req_vld[(m_rr + k) % 2] && req_cmd[(m_rr + k) % 2] != MEM_NONE) return (m_rr + k) % 2;
        end
        return -1;
    endfunction

    function automatic logic [1:0] m_rdy();
        int w = m_winner();
        return (w >= 0 && t_tag != 0) ? 2'(1 << w) : 2'b00;
    endfunction

    function automatic logic [1:0] m_rsp();
        return (d_tag != 0 && m_valid[d_tag]) ? 2'(1 << m_owner[d_tag]) : 2'b00;
    endfunction

    // Return is retired first, then any accepted load claims its tag.
    task automatic m_clock();
        int w = m_winner();
        if (d_tag != 0) begin
            if (m_valid[d_tag]) begin m_valid[d_tag] = 0; m_cnt--; end
            else m_stray = 1;
        end
        if (w >= 0 && t_tag != 0) begin
            m_rr = (w + 1) % 2;
            if (req_cmd[w] == MEM_LOAD) begin m_valid[t_tag] = 1; m_owner[t_tag] = w; m_cnt++; end
        end
    endtask

    task automatic tick();
        m_clock();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_vld = 2'b00;
        for (int i = 0; i < 2; i++) begin req_cmd[i] = MEM_NONE; req_addr[i] = '0; req_data[i] = '0; end
        t_tag = '0; d_tag = '0; m_data = '0;
    endtask

    task automatic set_req(input int i, input MEM_COMMAND c, input ADDR a, input MEM_BLOCK d);
        req_vld[i] = 1'b1; req_cmd[i] = c; req_addr[i] = a; req_data[i] = d;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_req(0, MEM_LOAD, 32'h40, 64'h1);
        set_req(1, MEM_STORE, 32'h80, 64'h2);
        t_tag = 4'd3; d_tag = 4'd3;
        #1;
        checks++; if (p_cmd !== MEM_NONE) begin errors++; $display("FAIL reset_cmd: got %0d expected %0d", p_cmd, MEM_NONE); end
        checks++; if (req_rdy !== 2'b00) begin errors++; $display("FAIL reset_rdy: got %b expected 00", req_rdy); end
        checks++; if (rsp_vld !== 2'b00) begin errors++; $display("FAIL reset_rsp: got %b expected 00", rsp_vld); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", idle); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (lo !== 5'd0) begin errors++; $display("FAIL reset_lo: got %0d expected 0", lo); end
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL reset_stray: got %b expected 0", stray); end
        idle_inputs();
        rst = 1'b1;
        m_reset();
        @(negedge clk);
    endtask

    task automatic test_single_load();
        set_req(0, MEM_LOAD, 32'h100, 64'hFFFF);
        t_tag = 4'd3;
        #1;
        checks++; if (req_rdy !== 2'b01) begin errors++; $display("FAIL load_rdy: got %b expected 01", req_rdy); end
        checks++; if (p_cmd !== MEM_LOAD) begin errors++; $display("FAIL load_cmd: got %0d expected %0d", p_cmd, MEM_LOAD); end
        checks++; if (p_addr !== 32'h100) begin errors++; $display("FAIL load_addr: got %h expected 100", p_addr); end
        checks++; if (p_data !== 64'h0) begin errors++; $display("FAIL load_data_zero: got %h expected 0", p_data); end
        tick();
        idle_inputs();
        #1;
        checks++; if (lo !== 5'd1 || idle !== 1'b0) begin errors++; $display("FAIL load_pending: got lo=%0d idle=%b expected lo=1 idle=0", lo, idle); end
        tick();
        d_tag = 4'd3; m_data = 64'hDEAD_BEEF;
        #1;
        checks++; if (rsp_vld !== 2'b01) begin errors++; $display("FAIL load_rsp_vld: got %b expected 01", rsp_vld); end
        checks++; if (rsp_data !== 64'hDEAD_BEEF) begin errors++; $display("FAIL load_rsp_data: got %h expected deadbeef", rsp_data); end
        tick();
        idle_inputs();
        #1;
        checks++; if (idle !== 1'b1 || lo !== 5'd0) begin errors++; $display("FAIL load_idle: got lo=%0d idle=%b expected lo=0 idle=1", lo, idle); end
    endtask

    task automatic test_contention();
        logic [1:0] prev = 2'b00;
        logic [1:0] exp;
        for (int c = 0; c < 4; c++) begin
            set_req(0, MEM_STORE, 32'h1000 + 32'(c), 64'hA000 + 64'(c));
            set_req(1, MEM_STORE, 32'h2000 + 32'(c), 64'hB000 + 64'(c));
            t_tag = MEM_TAG'($urandom_range(1, 15));
            exp = m_rdy();
            #1;
            checks++; if (req_rdy !== exp) begin errors++; $display("FAIL contention_rdy: got %b expected %b", req_rdy, exp); end
            checks++; if (c > 0 && req_rdy === prev) begin errors++; $display("FAIL contention_alternate: got %b expected not %b", req_rdy, prev); end
            checks++; if (p_data !== req_data[m_winner()]) begin errors++; $display("FAIL contention_data: got %h expected %h", p_data, req_data[m_winner()]); end
            prev = req_rdy;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_rejection();
        ADDR first;
        int w;
        set_req(0, MEM_STORE, 32'h3000, 64'h11);
        set_req(1, MEM_STORE, 32'h4000, 64'h22);
        w = m_winner();
        first = req_addr[w];
        for (int c = 0; c < 3; c++) begin
            t_tag = '0;
            #1;
            checks++; if (req_rdy !== 2'b00) begin errors++; $display("FAIL reject_rdy: got %b expected 00", req_rdy); end
            checks++; if (p_addr !== first) begin errors++; $display("FAIL reject_winner: got %h expected %h", p_addr, first); end
            tick();
        end
        t_tag = 4'd7;
        #1;
        checks++; if (req_rdy !== 2'(1 << w)) begin errors++; $display("FAIL reject_retry: got %b expected %b", req_rdy, 2'(1 << w)); end
        tick();
        idle_inputs();
    endtask

    task automatic test_interleaved();
        set_req(0, MEM_LOAD, 32'h200, '0); t_tag = 4'd5;
        #1;
        checks++; if (req_rdy !== 2'b01) begin errors++; $display("FAIL inter_rdy0: got %b expected 01", req_rdy); end
        tick();
        idle_inputs();
        set_req(1, MEM_LOAD, 32'h240, '0); t_tag = 4'd6;
        #1;
        checks++; if (req_rdy !== 2'b10) begin errors++; $display("FAIL inter_rdy1: got %b expected 10", req_rdy); end
        tick();
        idle_inputs();
        d_tag = 4'd6; m_data = 64'h66;
        #1;
        checks++; if (lo !== 5'd2) begin errors++; $display("FAIL inter_lo2: got %0d expected 2", lo); end
        checks++; if (rsp_vld !== 2'b10) begin errors++; $display("FAIL inter_rsp6: got %b expected 10", rsp_vld); end
        tick();
        d_tag = 4'd5; m_data = 64'h55;
        #1;
        checks++; if (lo !== 5'd1) begin errors++; $display("FAIL inter_lo1: got %0d expected 1", lo); end
        checks++; if (rsp_vld !== 2'b01 || rsp_data !== 64'h55) begin errors++; $display("FAIL inter_rsp5: got %b/%h expected 01/55", rsp_vld, rsp_data); end
        tick();
        idle_inputs();
        #1;
        checks++; if (lo !== 5'd0) begin errors++; $display("FAIL inter_lo0: got %0d expected 0", lo); end
    endtask

    task automatic test_same_cycle();
        set_req(0, MEM_LOAD, 32'h300, '0); t_tag = 4'd4;
        #1;
        checks++; if (req_rdy !== 2'b01) begin errors++; $display("FAIL reuse_issue: got %b expected 01", req_rdy); end
        tick();
        idle_inputs();
        set_req(1, MEM_LOAD, 32'h340, '0); t_tag = 4'd4; d_tag = 4'd4; m_data = 64'h44;
        #1;
        checks++; if (rsp_vld !== 2'b01) begin errors++; $display("FAIL reuse_rsp: got %b expected 01", rsp_vld); end
        checks++; if (req_rdy !== 2'b10) begin errors++; $display("FAIL reuse_rdy: got %b expected 10", req_rdy); end
        tick();
        idle_inputs();
        #1;
        checks++; if (lo !== 5'd1) begin errors++; $display("FAIL reuse_lo: got %0d expected 1", lo); end
        d_tag = 4'd4;
        #1;
        checks++; if (rsp_vld !== 2'b10) begin errors++; $display("FAIL reuse_owner: got %b expected 10", rsp_vld); end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_midflight();
        set_req(0, MEM_LOAD, 32'h500, '0); t_tag = 4'd2;
        tick();
        idle_inputs();
        #1;
        checks++; if (lo !== 5'd1) begin errors++; $display("FAIL midrst_pending: got %0d expected 1", lo); end
        rst = 1'b0;
        m_reset();
        #2;
        checks++; if (lo !== 5'd0 || idle !== 1'b1) begin errors++; $display("FAIL midrst_async: got lo=%0d idle=%b expected lo=0 idle=1", lo, idle); end
        rst = 1'b1;
        @(negedge clk);
        d_tag = 4'd2; m_data = 64'h22;
        #1;
        checks++; if (rsp_vld !== 2'b00) begin errors++; $display("FAIL midrst_rsp: got %b expected 00", rsp_vld); end
        tick();
        idle_inputs();
        #1;
        checks++; if (stray !== 1'b1) begin errors++; $display("FAIL midrst_stray: got %b expected 1", stray); end
        checks++; if (lo !== 5'd0) begin errors++; $display("FAIL midrst_lo: got %0d expected 0", lo); end
    endtask

    task automatic test_random();
        bit         pv [2];
        MEM_COMMAND pc [2];
        ADDR        pa [2];
        MEM_BLOCK   pd [2];
        int         vl [$];
        int         w, r, t;
        logic [1:0] e_rdy, e_rsp;
        MEM_COMMAND e_cmd;
        for (int i = 0; i < 2; i++) pv[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pv[i] && $urandom_range(0, 1) == 1) begin
                    r = int'($urandom_range(0, 9));
                    pv[i] = 1;
                    pc[i] = (r == 0) ? MEM_NONE : (r < 6) ? MEM_LOAD : MEM_STORE;
                    pa[i] = $urandom & 32'hFFFF_FFC0;
                    pd[i] = {$urandom, $urandom};
                end
                req_vld[i] = pv[i]; req_cmd[i] = pc[i]; req_addr[i] = pa[i]; req_data[i] = pd[i];
            end
            vl.delete();
            for (int k = 1; k < 16; k++) if (m_valid[k]) vl.push_back(k);
            r = int'($urandom_range(0, 99));
            d_tag = (r < 5) ? MEM_TAG'($urandom_range(1, 15)) :
                    (r < 55 && vl.size() > 0) ? MEM_TAG'(vl[$urandom_range(0, vl.size() - 1)]) : '0;
            m_data = {$urandom, $urandom};
            t_tag = '0;
            if ($urandom_range(0, 3) != 0) begin
                for (int k = 0; k < 8 && t_tag == 0; k++) begin
                    t = int'($urandom_range(1, 15));
                    if (!m_valid[t] || t == int'(d_tag)) t_tag = MEM_TAG'(t);
                end
            end
            w = m_winner();
            e_rdy = m_rdy();
            e_rsp = m_rsp();
            e_cmd = (w >= 0) ? req_cmd[w] : MEM_NONE;
            #1;
            checks++; if (req_rdy !== e_rdy) begin errors++; $display("FAIL rand_rdy c=%0d: got %b expected %b", c, req_rdy, e_rdy); end
            checks++; if (rsp_vld !== e_rsp) begin errors++; $display("FAIL rand_rsp c=%0d: got %b expected %b", c, rsp_vld, e_rsp); end
            checks++; if (p_cmd !== e_cmd) begin errors++; $display("FAIL rand_cmd c=%0d: got %0d expected %0d", c, p_cmd, e_cmd); end
            checks++; if (p_addr !== ((w >= 0) ? req_addr[w] : 32'h0)) begin errors++; $display("FAIL rand_addr c=%0d: got %h", c, p_addr); end
            checks++; if (p_data !== ((e_cmd == MEM_STORE) ? req_data[w] : 64'h0)) begin errors++; $display("FAIL rand_data c=%0d: got %h", c, p_data); end
            if (e_rsp != 2'b00) begin
                checks++; if (rsp_data !== m_data) begin errors++; $display("FAIL rand_rsp_data c=%0d: got %h expected %h", c, rsp_data, m_data); end
            end
            checks++; if (lo !== 5'(m_cnt) || idle !== (m_cnt == 0)) begin errors++; $display("FAIL rand_lo c=%0d: got %0d/%b expected %0d", c, lo, idle, m_cnt); end
            checks++; if (stray !== m_stray) begin errors++; $display("FAIL rand_stray c=%0d: got %b expected %b", c, stray, m_stray); end
            tick();
            for (int i = 0; i < 2; i++) if (pc[i] == MEM_NONE || (e_rdy[i] && pv[i])) pv[i] = 0;
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        m_reset();
        test_reset();
        test_single_load();
        test_contention();
        test_rejection();
        test_interleaved();
        test_same_cycle();
        test_reset_midflight();
        rst = 1'b0;
        m_reset();
        #2;
        rst = 1'b1;
        @(negedge clk);
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
